// File: rtl/pc_seq_ctl_pkg.sv
// Shared encodings for the PC sequencing controller: pc_gen override codes
// and the controller's state codes.
package pc_seq_ctl_pkg;

   localparam logic [3:0] PC_IGN = 4'b0001;
   localparam logic [3:0] PC_KEP = 4'b0010;
   localparam logic [3:0] PC_IRQ = 4'b0100;
   localparam logic [3:0] PC_RST = 4'b1000;

   localparam logic [1:0] SEQ_RST  = 2'd0;
   localparam logic [1:0] SEQ_RUN  = 2'd1;
   localparam logic [1:0] SEQ_TAKE = 2'd2;
   localparam logic [1:0] SEQ_ISR  = 2'd3;

endpackage

// File: rtl/pc_seq_cnt.sv
// Loadable saturating down/up counter shared by reset stretch and watchdog.
// Priority: load > clr > dn > up; never wraps in either direction.
module pc_seq_cnt #(
   parameter int CNT_W     = 8,
   parameter int RST_VAL   = 3,
   parameter int MATCH_VAL = 254
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic clr,
   input  logic dn,
   input  logic up,
   output logic zero,
   output logic match
);

   localparam logic [CNT_W-1:0] RST_V   = CNT_W'(RST_VAL);
   localparam logic [CNT_W-1:0] MATCH_V = CNT_W'(MATCH_VAL);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= RST_V;
      end else if (load) begin
         cnt <= RST_V;
      end else if (clr) begin
         cnt <= '0;
      end else if (dn && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end else if (up && cnt != '1) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign zero  = (cnt == '0);
   assign match = (cnt == MATCH_V);

endmodule

// File: rtl/pc_seq_ctl.sv
// PC / register-file sequencing controller: reset stretch, stall freeze, IRQ take.
// Optional stall watchdog is built when PCSEQ_STALL_WDOG_EN is defined.
module pc_seq_ctl
   import pc_seq_ctl_pkg::*;
#(
   parameter int RST_CYCLES = 4,
   parameter int STALL_MAX  = 255,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stall_i,
   input  logic       irq_i,
   input  logic       ds_i,
   input  logic       ret_i,
   output logic [3:0] pc_prectl_o,
   output logic       rd_clk_cls_o,
   output logic       spc_we_o,
   output logic       irq_ack_o,
   output logic       flush_o,
   output logic       in_isr_o,
   output logic       stall_err_o
);

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       cnt_load;
   logic       cnt_clr;
   logic       cnt_dn;
   logic       cnt_up;
   logic       cnt_zero;
   logic       cnt_match;
   logic       trip;

   // Match one short of STALL_MAX: trip on the cycle the count would reach it.
   pc_seq_cnt #(
      .CNT_W    (CNT_W),
      .RST_VAL  (RST_CYCLES - 1),
      .MATCH_VAL(STALL_MAX - 1)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .clr  (cnt_clr),
      .dn   (cnt_dn),
      .up   (cnt_up),
      .zero (cnt_zero),
      .match(cnt_match)
   );

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_clr  = 1'b0;
      cnt_dn   = 1'b0;
      cnt_up   = 1'b0;
      trip     = 1'b0;
      unique case (state_q)
         SEQ_RST: begin
            if (cnt_zero) state_d = SEQ_RUN;
            else          cnt_dn  = 1'b1;
         end
         SEQ_RUN: begin
            if (!stall_i && irq_i && !ds_i) state_d = SEQ_TAKE;
         end
         SEQ_TAKE: state_d = SEQ_ISR;
         SEQ_ISR: begin
            if (!stall_i && ret_i) state_d = SEQ_RUN;
         end
         default: state_d = SEQ_RST;
      endcase
`ifdef PCSEQ_STALL_WDOG_EN
      if (state_q != SEQ_RST) begin
         if (stall_i) cnt_up  = 1'b1;
         else         cnt_clr = 1'b1;
         if (stall_i && cnt_match && state_q != SEQ_TAKE) begin
            trip     = 1'b1;
            state_d  = SEQ_RST;
            cnt_load = 1'b1;
         end
      end
`endif
   end

`ifndef PCSEQ_STALL_WDOG_EN
   logic unused_match;
   assign unused_match = cnt_match;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= SEQ_RST;
      else     state_q <= state_d;
   end

   always_comb begin
      pc_prectl_o  = PC_IGN;
      rd_clk_cls_o = 1'b0;
      spc_we_o     = 1'b0;
      irq_ack_o    = 1'b0;
      flush_o      = 1'b0;
      in_isr_o     = 1'b0;
      unique case (state_q)
         SEQ_TAKE: begin
            pc_prectl_o  = PC_IRQ;
            rd_clk_cls_o = 1'b1;
            spc_we_o     = 1'b1;
            irq_ack_o    = 1'b1;
            flush_o      = 1'b1;
         end
         SEQ_RUN, SEQ_ISR: begin
            in_isr_o = (state_q == SEQ_ISR);
            if (stall_i) begin
               pc_prectl_o  = PC_KEP;
               rd_clk_cls_o = 1'b1;
            end
         end
         default: begin
            pc_prectl_o  = PC_RST;
            rd_clk_cls_o = 1'b1;
         end
      endcase
   end

   assign stall_err_o = trip;

endmodule
